// File: rtl/seq_mul4.sv
// seq_mul4: 4x4 shift-add sequential multiplier, unsigned or two's complement.
// One result every 6 cycles: capture, 4 shift-add steps, 1-cycle done pulse.
module seq_mul4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sgn,
  output logic       busy,
  output logic       done,
  output logic [7:0] p
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] r_state;
  logic [3:0] r_mcand;
  logic [3:0] r_mlr;
  logic [3:0] r_acc;
  logic [1:0] r_cnt;
  logic       r_neg;
  logic [7:0] r_p;

  logic [3:0] w_mag_a;
  logic [3:0] w_mag_b;
  logic [4:0] w_sum;
  logic [7:0] w_prod;

  // Magnitude of -8 wraps back to 4'b1000, read as unsigned 8.
  assign w_mag_a = (sgn && a[3]) ? (~a + 4'd1) : a;
  assign w_mag_b = (sgn && b[3]) ? (~b + 4'd1) : b;

  assign w_sum  = {1'b0, r_acc} + (r_mlr[0] ? {1'b0, r_mcand} : 5'd0);
  // {carry, acc, mlr} shifted right by one after the add.
  assign w_prod = {w_sum, r_mlr[3:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mcand <= 4'd0;
      r_mlr   <= 4'd0;
      r_acc   <= 4'd0;
      r_cnt   <= 2'd0;
      r_neg   <= 1'b0;
      r_p     <= 8'h00;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= w_mag_a;
            r_mlr   <= w_mag_b;
            r_neg   <= sgn & (a[3] ^ b[3]);
            r_acc   <= 4'd0;
            r_cnt   <= 2'd0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_sum[4:1];
          r_mlr <= {w_sum[0], r_mlr[3:1]};
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_p     <= r_neg ? (~w_prod + 8'd1) : w_prod;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign p    = r_p;

endmodule

// File: doc/seq_mul4.md
SEQ_MUL4 -- requirements
Module: seq_mul4

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port start, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-004 The block SHALL have the port a, input, 4 bits: multiplicand; captured when start is accepted.
REQ-005 The block SHALL have the port b, input, 4 bits: multiplier; captured when start is accepted.
REQ-006 The block SHALL have the port sgn, input, 1 bit: 1 = a and b are two's complement, 0 = unsigned; captured when start is accepted.
REQ-007 The block SHALL have the port busy, output, 1 bit: high in any state other than IDLE.
REQ-008 The block SHALL have the port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-009 The block SHALL have the port p, output, 8 bits: product register, held stable between completions.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, RUN and DONE; no other state reachable.
REQ-011 In IDLE with start=1 at edge E0, the block SHALL do all of the following: capture a, b and sgn; clear the 4-bit accumulator and the 2-bit step counter; enter RUN.
REQ-012 In IDLE with start=0, the block SHALL hold all registers.
REQ-013 Operand conditioning: if sgn=1, the captured multiplicand and multiplier SHALL be their magnitudes (a[3] set -> two's-complement negate), and neg = a[3] XOR b[3] SHALL be latched.
REQ-014 Operand conditioning: if sgn=0, operands SHALL be taken as-is and neg=0 SHALL be latched.
REQ-015 Magnitude of -8 SHALL be 8 (4-bit unsigned 1000); no saturation.
REQ-016 Each RUN cycle SHALL perform one shift-add step: if multiplier LSB=1, {carry, acc} = acc + mcand (5-bit sum), else {carry, acc} = {0, acc}.
REQ-017 Each RUN cycle SHALL then shift {carry, acc, mlr} right by one bit.
REQ-018 Each RUN cycle SHALL increment the step counter.
REQ-019 RUN SHALL last exactly 4 cycles (edges E1..E4); after the 4th step, {acc, mlr} holds the 8-bit unsigned magnitude product.
REQ-020 At edge E4 the FSM SHALL enter DONE.
REQ-021 At edge E4, p SHALL load the product, two's-complement negated if neg=1.
REQ-022 DONE SHALL last one cycle with done=1; at edge E5 the FSM SHALL return to IDLE and done SHALL drop to 0.
REQ-023 Latency SHALL be: start accepted at E0 -> done=1 and p valid in the cycle after E4; busy=1 from after E0 until E5.
REQ-024 start SHALL be ignored while busy=1; operands SHALL not be re-captured, and in-flight operation is unaffected.
REQ-025 start=1 held continuously SHALL produce back-to-back operations: a new capture at E5 (IDLE is entered, start sampled on the following edge), giving one result per 6 cycles.
REQ-026 Unsigned results SHALL range 0..225; signed results SHALL range -56..64, all representable in 8 bits; no overflow flag.
REQ-027 p SHALL change only at the RUN->DONE transition or on reset.
REQ-028 Changing a, b or sgn during RUN SHALL NOT affect the result.

Reset
REQ-029 With rst=1 at a rising edge, the block SHALL do all of the following regardless of state: FSM -> IDLE; busy=0; done=0; p=8'h00; accumulator, counter and operand registers cleared.
REQ-030 rst SHALL have priority over start on the same edge; no operation begins.
REQ-031 Reset mid-RUN or in DONE SHALL abort with no done pulse and p=8'h00.
REQ-032 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-033 The bench SHALL check unsigned: sgn=0, a=13, b=11, start pulse -> done one cycle after E4, p=8'h8F, busy low after E5.
REQ-034 The bench SHALL check signed corner cases: sgn=1, a=4'h8, b=4'h8 -> p=8'h40; sgn=1, a=4'hD (-3), b=4'h5 -> p=8'hF1 (-15); sgn=1, a=0, b=4'h8 -> p=8'h00.
REQ-035 The bench SHALL check exhaustive: all 256 a/b pairs x both sgn values against a reference model; done exactly once per start, 6 cycles per operation.
REQ-036 The bench SHALL check busy behaviour: start re-asserted with new a/b during RUN -> ignored, result from original operands, single done pulse.
REQ-037 The bench SHALL check reset mid-operation: rst at E2 -> busy=0, done never pulses, p=8'h00; next start (a=15, b=15, sgn=0) -> p=8'hE1.
REQ-038 The bench SHALL check start held high for 3 operations: done pulses spaced exactly 6 cycles apart, p updated each time.
